// File: rtl/input_skew_scheduler.sv
// input_skew_scheduler: diagonal input skew for a systolic array, lane i delayed i+1 cycles.
// Define SKEW_REVERSE_EN to reverse the output lane order after the skew.
module input_skew_scheduler #(
  parameter int LENGTH     = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   cfg_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LENGTH*DATA_WIDTH-1:0] in,
  output logic [LENGTH*DATA_WIDTH-1:0] out,
  output logic [LENGTH-1:0]            out_valid,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [4:0] DLAST = 5'(LENGTH - 1);

  state_t     state;
  logic [7:0] len;
  logic [7:0] vcnt;
  logic [7:0] vcnt_nxt;
  logic [4:0] dcnt;
  logic       accept;

  logic [DATA_WIDTH-1:0] lane_d [LENGTH];
  logic [LENGTH-1:0]     lane_v;

  assign accept   = (state == FEED) && in_valid;
  assign vcnt_nxt = vcnt + 8'd1;

  assign in_ready = (state == FEED);
  assign busy     = (state != IDLE);
  assign done     = (state == DRAIN) && (dcnt == DLAST);

  // Tile sequencing: latch length, count accepts, then drain LENGTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      vcnt  <= '0;
      dcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (cfg_len != 8'd0)) begin
            len   <= cfg_len;
            vcnt  <= '0;
            dcnt  <= '0;
            state <= FEED;
          end
        end
        FEED: begin
          if (accept) begin
            vcnt <= vcnt_nxt;
            if (vcnt_nxt == len) begin
              dcnt  <= '0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (dcnt == DLAST) begin
            dcnt  <= '0;
            state <= IDLE;
          end else begin
            dcnt <= dcnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LENGTH; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] sd [i+1];
    logic [i:0]            sv;

    // Lane delay line: shifts every busy cycle, bubbles when nothing accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < i + 1; k++) sd[k] <= '0;
        sv <= '0;
      end else if (state == IDLE) begin
        for (int k = 0; k < i + 1; k++) sd[k] <= '0;
        sv <= '0;
      end else begin
        sd[0] <= accept ? in[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH] : '0;
        sv[0] <= accept;
        for (int k = 1; k < i + 1; k++) begin
          sd[k] <= sd[k-1];
          sv[k] <= sv[k-1];
        end
      end
    end

    assign lane_d[i] = sd[i];
    assign lane_v[i] = sv[i];
  end

  for (genvar j = 0; j < LENGTH; j++) begin : g_out
`ifdef SKEW_REVERSE_EN
    localparam int S = LENGTH - 1 - j;
`else
    localparam int S = j;
`endif
    assign out[DATA_WIDTH*(j+1)-1 -: DATA_WIDTH] =
      lane_v[S] ? lane_d[S] : '0;
    assign out_valid[j] = lane_v[S];
  end

endmodule

// File: tb/tb_input_skew_scheduler.sv
// tb_input_skew_scheduler: scoreboard bench, LENGTH=4, DATA_WIDTH=8.
// Build with SKEW_REVERSE_EN to check the reversed lane order.
module tb_input_skew_scheduler;

  localparam int L  = 4;
  localparam int DW = 8;

  logic            clk = 0;
  logic            rst_n;
  logic            start;
  logic [7:0]      cfg_len;
  logic            in_valid;
  logic            in_ready;
  logic [L*DW-1:0] in;
  logic [L*DW-1:0] out;
  logic [L-1:0]    out_valid;
  logic            busy;
  logic            done;

  input_skew_scheduler #(.LENGTH(L), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in(in), .out(out),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t lq [L][$];
  int   dq [$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tile_len = 0;
  int   acc_n = 0;

  task automatic chk(input bit ok, input string name,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Acceptance observer: pushes expected lane outputs and done cycle.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      for (int i = 0; i < L; i++) begin
        exp_t e;
        e.d = in[DW*i +: DW];
        e.c = cyc + i + 1;
        lq[i].push_back(e);
      end
      acc_n++;
      if (acc_n == tile_len) dq.push_back(cyc + L);
    end
  end

  // Monitor: compares every presented lane and done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < L; j++) begin
        int            li;
        logic [DW-1:0] od;
`ifdef SKEW_REVERSE_EN
        li = L - 1 - j;
`else
        li = j;
`endif
        od = out[DW*j +: DW];
        if (out_valid[j]) begin
          if (lq[li].size() == 0) begin
            chk(0, "unexpected_valid", j, li);
          end else begin
            exp_t e;
            e = lq[li].pop_front();
            chk(e.c == cyc, "lane_cycle", cyc, e.c);
            chk(e.d == od, "lane_data", od, e.d);
          end
        end else begin
          chk(od == '0, "bubble_zero", od, 0);
          if (lq[li].size() != 0 && lq[li][0].c <= cyc) begin
            chk(0, "missing_valid", li, lq[li][0].c);
            void'(lq[li].pop_front());
          end
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk(0, "unexpected_done", cyc, 0);
        end else begin
          int d;
          d = dq.pop_front();
          chk(d == cyc, "done_cycle", cyc, d);
        end
      end else if (dq.size() != 0 && dq[0] <= cyc) begin
        chk(0, "missing_done", cyc, dq[0]);
        void'(dq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input int n);
    start   = 1;
    cfg_len = 8'(n);
    if (n != 0) begin
      tile_len = n;
      acc_n    = 0;
    end
    step();
    start   = 0;
    cfg_len = 8'd99;
  endtask

  task automatic send(input logic [L*DW-1:0] v);
    in_valid = 1;
    in       = v;
    step();
    in_valid = 0;
    in       = '0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      step();
    end
    chk(seen, name, seen, 1);
  endtask

  initial begin
    rst_n    = 0;
    start    = 0;
    cfg_len  = 0;
    in_valid = 0;
    in       = '0;
    step();
    step();
    chk(out == '0, "rst_out", out, 0);
    chk(out_valid == '0, "rst_out_valid", out_valid, 0);
    chk(!busy, "rst_busy", busy, 0);
    chk(!in_ready, "rst_in_ready", in_ready, 0);
    chk(!done, "rst_done", done, 0);
    rst_n = 1;
    step();

    // single vector tile, lanes 3..0 = 4,3,2,1
    start_tile(1);
    chk(busy && in_ready, "feed_entry", {busy, in_ready}, 3);
    send({8'd4, 8'd3, 8'd2, 8'd1});
    chk(!in_ready, "drain_in_ready", in_ready, 0);
    wait_done("t1_done");
    step();
    chk(!busy, "t1_idle", busy, 0);
    chk(out_valid == '0, "t1_idle_valid", out_valid, 0);

    // three back-to-back vectors
    start_tile(3);
    send({4{8'd1}});
    in_valid = 1;
    in       = {4{8'd2}};
    step();
    in = {4{8'd3}};
    step();
    in_valid = 0;
    in       = '0;
`ifdef SKEW_REVERSE_EN
    chk(out == 32'h03020100, "t3_diag", out, 32'h03020100);
    chk(out_valid == 4'b1110, "t3_diag_v", out_valid, 4'b1110);
`else
    chk(out == 32'h00010203, "t3_diag", out, 32'h00010203);
    chk(out_valid == 4'b0111, "t3_diag_v", out_valid, 4'b0111);
`endif
    wait_done("t3_done");
    step();

    // gap of two idle cycles between vectors
    start_tile(2);
    send({8'h1d, 8'h1c, 8'h1b, 8'h1a});
    chk(in_ready, "gap_ready0", in_ready, 1);
    step();
    chk(in_ready, "gap_ready1", in_ready, 1);
    step();
    send({8'h2d, 8'h2c, 8'h2b, 8'h2a});
    chk(!in_ready, "gap_drain", in_ready, 0);
    wait_done("gap_done");
    step();

    // zero-length start ignored
    start_tile(0);
    chk(!busy, "zero_busy", busy, 0);
    chk(!in_ready, "zero_ready", in_ready, 0);

    // start during drain ignored
    start_tile(2);
    send({8'h44, 8'h33, 8'h22, 8'h11});
    send({8'h88, 8'h77, 8'h66, 8'h55});
    step();
    start   = 1;
    cfg_len = 8'd5;
    step();
    start = 0;
    wait_done("drain_start_done");
    step();
    for (int k = 0; k < 6; k++) begin
      chk(!busy, "drain_start_idle", busy, 0);
      step();
    end

    // reset mid-feed after two accepts
    start_tile(4);
    send({8'h0d, 8'h0c, 8'h0b, 8'h0a});
    send({8'h1d, 8'h1c, 8'h1b, 8'h1a});
    #2;
    rst_n = 0;
    #1;
    chk(out == '0, "abort_out", out, 0);
    chk(out_valid == '0, "abort_valid", out_valid, 0);
    chk(!busy, "abort_busy", busy, 0);
    for (int i = 0; i < L; i++) lq[i].delete();
    dq.delete();
    step();
    rst_n = 1;
    step();
    for (int k = 0; k < 6; k++) begin
      chk(!done && !busy, "abort_no_done", {done, busy}, 0);
      step();
    end

    start_tile(1);
    send({8'hf4, 8'hf3, 8'hf2, 8'hf1});
    wait_done("fresh_done");
    step();
    chk(!busy, "fresh_idle", busy, 0);

    repeat (6) step();
    begin
      int left;
      left = dq.size();
      for (int i = 0; i < L; i++) left += lq[i].size();
      chk(left == 0, "queues_empty", left, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
